// File: rtl/contador_delay_n.sv
`default_nettype none
// ============================================================================
// Module   : contador_delay_n
// Brief    : DEPTH-stage delay line for a counter value plus valid tag, with a
//            runtime tap, stall, synchronous flush and fill-status flag.
// Revision : 1.0 - initial release
// ============================================================================
module contador_delay_n #(
  parameter  int               WIDTH     = 6,
  parameter  int               DEPTH     = 2,
  parameter  logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
  localparam int               TAPW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int               FILLW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] counter_in,
  input  logic             counter_in_valid,
  input  logic [TAPW-1:0]  tap_sel,
  output logic [WIDTH-1:0] counter_out,
  output logic             counter_out_valid,
  output logic [WIDTH-1:0] counter_tap,
  output logic             counter_tap_valid,
  output logic             primed
);

  localparam logic [FILLW-1:0] c_fill_max  = FILLW'(DEPTH);
  localparam logic [TAPW-1:0]  c_last_idx  = TAPW'(DEPTH - 1);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [FILLW-1:0] r_fill;
  logic [TAPW-1:0]  w_tap_idx;

  // Flush takes priority over en; invalid slots shift like any other entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= RESET_VAL;
      end
      r_vld  <= '0;
      r_fill <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= RESET_VAL;
      end
      r_vld  <= '0;
      r_fill <= '0;
    end else if (en) begin
      r_stage[0] <= counter_in;
      r_vld[0]   <= counter_in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
        r_vld[i]   <= r_vld[i-1];
      end
      if (r_fill != c_fill_max) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  // Tap index saturates to the last stage for out-of-range selections.
  always_comb begin
    w_tap_idx = tap_sel;
    if (tap_sel > c_last_idx) begin
      w_tap_idx = c_last_idx;
    end
  end

  assign counter_out       = r_stage[DEPTH-1];
  assign counter_out_valid = r_vld[DEPTH-1];
  assign counter_tap       = r_stage[w_tap_idx];
  assign counter_tap_valid = r_vld[w_tap_idx];
  assign primed            = (r_fill == c_fill_max);

endmodule
`default_nettype wire

// File: tb/tb_contador_delay_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_contador_delay_n
// Brief    : Randomized bench for contador_delay_n at DEPTH = 2, 4, 5 and 8,
//            compared against a history-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_contador_delay_n;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       flush;
  logic [5:0] counter_in;
  logic       counter_in_valid;
  logic [2:0] tap_sel;

  logic [5:0] o2, t2, o4, t4, o5, t5, o8, t8;
  logic       ov2, tv2, p2, ov4, tv4, p4, ov5, tv5, p5, ov8, tv8, p8;

  int vectors     = 0;
  int miscompares = 0;

  // Each queue holds {valid, value} of every accepted entry since the last clear,
  // newest at the back; stage i holds the entry accepted i advances ago.
  logic [6:0] h2[$], h4[$], h5[$], h8[$];

  always #5 clk = ~clk;

  contador_delay_n #(.WIDTH(6), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .counter_in(counter_in), .counter_in_valid(counter_in_valid), .tap_sel(tap_sel[0]),
    .counter_out(o2), .counter_out_valid(ov2), .counter_tap(t2), .counter_tap_valid(tv2),
    .primed(p2));

  contador_delay_n #(.WIDTH(6), .DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .counter_in(counter_in), .counter_in_valid(counter_in_valid), .tap_sel(tap_sel[1:0]),
    .counter_out(o4), .counter_out_valid(ov4), .counter_tap(t4), .counter_tap_valid(tv4),
    .primed(p4));

  contador_delay_n #(.WIDTH(6), .DEPTH(5)) u_d5 (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .counter_in(counter_in), .counter_in_valid(counter_in_valid), .tap_sel(tap_sel),
    .counter_out(o5), .counter_out_valid(ov5), .counter_tap(t5), .counter_tap_valid(tv5),
    .primed(p5));

  contador_delay_n #(.WIDTH(6), .DEPTH(8)) u_d8 (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .counter_in(counter_in), .counter_in_valid(counter_in_valid), .tap_sel(tap_sel),
    .counter_out(o8), .counter_out_valid(ov8), .counter_tap(t8), .counter_tap_valid(tv8),
    .primed(p8));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] entry_at(input logic [6:0] q[$], input int i);
    if (i < q.size()) return q[q.size() - 1 - i];
    return {1'b0, 6'd63};
  endfunction

  // Expected {out_valid, out, tap_valid, tap, primed} for a line of depth d.
  function automatic logic [14:0] expect_vec(input logic [6:0] q[$], input int d, input int sel);
    int k;
    k = (sel >= d) ? d : sel + 1;
    return {entry_at(q, d - 1), entry_at(q, k - 1), (q.size() >= d)};
  endfunction

  task automatic check_all(input string phase);
    check({phase, "_d2"}, 32'({ov2, o2, tv2, t2, p2}), 32'(expect_vec(h2, 2, int'(tap_sel[0]))));
    check({phase, "_d4"}, 32'({ov4, o4, tv4, t4, p4}), 32'(expect_vec(h4, 4, int'(tap_sel[1:0]))));
    check({phase, "_d5"}, 32'({ov5, o5, tv5, t5, p5}), 32'(expect_vec(h5, 5, int'(tap_sel))));
    check({phase, "_d8"}, 32'({ov8, o8, tv8, t8, p8}), 32'(expect_vec(h8, 8, int'(tap_sel))));
  endtask

  task automatic clear_models();
    h2.delete(); h4.delete(); h5.delete(); h8.delete();
  endtask

  task automatic push_models(input logic [6:0] e);
    h2.push_back(e); h4.push_back(e); h5.push_back(e); h8.push_back(e);
    if (h2.size() > 64) void'(h2.pop_front());
    if (h4.size() > 64) void'(h4.pop_front());
    if (h5.size() > 64) void'(h5.pop_front());
    if (h8.size() > 64) void'(h8.pop_front());
  endtask

  // One clock: drive at negedge, check before the edge (also proves outputs do not
  // follow counter_in/en/flush combinationally), optional async reset pulse, then edge.
  task automatic cycle(input logic e, input logic f, input logic v, input logic [5:0] val,
                       input logic [2:0] ts, input logic rpulse);
    @(negedge clk);
    en = e; flush = f; counter_in_valid = v; counter_in = val; tap_sel = ts;
    #1 check_all("pre");
    if (rpulse) begin
      reset = 1'b1;
      #1;
      clear_models();
      check_all("arst");
      #1 reset = 1'b0;
    end
    @(posedge clk);
    if (f) clear_models();
    else if (e) push_models({v, val});
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; flush = 1'b0;
    counter_in = '0; counter_in_valid = 1'b0; tap_sel = '0;
    #1;
    clear_models();
    check_all("por");
    #2 reset = 1'b0;

    // Ramp with counter wrap, valid held high.
    for (int i = 0; i < 70; i++) cycle(1'b1, 1'b0, 1'b1, 6'(i % 64), 3'($urandom), 1'b0);

    // Stall: feed 10,11,12, hold three cycles, resume; then flush with en on the same edge.
    for (int i = 10; i < 13; i++) cycle(1'b1, 1'b0, 1'b1, 6'(i), 3'd7, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 6'($urandom), 3'd7, 1'b0);
    for (int i = 13; i < 20; i++) cycle(1'b1, 1'b0, 1'b1, 6'(i), 3'(i % 8), 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 6'd55, 3'd3, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 6'(20 + i), 3'(i % 8), 1'b0);

    // Tap sweep with valid bubbles on alternate cycles.
    for (int i = 0; i < 48; i++) cycle(1'b1, 1'b0, 1'(i % 2 == 0), 6'(i), 3'(i % 8), 1'b0);

    // Async reset in the middle of a running ramp, then refill.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 6'(i), 3'(i % 8), 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 6'd10, 3'd7, 1'b1);
    for (int i = 11; i < 25; i++) cycle(1'b1, 1'b0, 1'b1, 6'(i), 3'(i % 8), 1'b0);

    // Random mix of enable, flush, bubbles, tap selection and async resets.
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(3, 0) != 0), 1'($urandom_range(19, 0) == 0), 1'($urandom),
            6'($urandom), 3'($urandom), 1'($urandom_range(49, 0) == 0));
    end

    @(negedge clk);
    #1 check_all("end");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
